tbird_controller: RTL and testbench
===================================

Name: tbird_controller

Overview:
- Full Thunderbird tail-light controller driving two mirrored 3-lamp banks.
- The right bank sequences outward A, AB, ABC, off. The left bank runs the same sequence in the opposite physical direction.
- Also provides hazard flashing and a brake overlay.
- Sits between the switch/key inputs and the LEDR outputs at top level. A prescaler sets the visible sequencing rate.

Parameters:
- TICK_DIV, 1, clocks per sequencer step (must be >= 1). A value of 1 advances on every clk.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk
- left  input  1  left turn request, level
- right  input  1  right turn request, level
- hazard  input  1  hazard request, level
- brake  input  1  brake pedal, level
- lamp_l  output  3  left bank; bit0 = LA (innermost), bit2 = LC (outermost)
- lamp_r  output  3  right bank; bit0 = RA (innermost), bit2 = RC (outermost)

Behaviour:
- Interface (decided): one clock, clk; reset is synchronous and active-high.

Reset:
- While reset is high at a clk edge: state <= IDLE, prescaler <= 0, lamp_l <= 000, lamp_r <= 000.
- Reset overrides all other inputs, including mid-sequence and mid-hazard.

Prescaler (tick):
- Counter runs 0..TICK_DIV-1 and wraps to 0.
- tick = (count == TICK_DIV-1).
- Counter width = max(1, clog2(TICK_DIV)).
- The state register advances only on a tick.

States: IDLE, L1, L2, L3, R1, R2, R3, HAZ.

Transitions, evaluated on tick only:
- IDLE, request decode in priority order:
  - hazard=1, or left=1 and right=1 -> HAZ
  - left=1 -> L1
  - right=1 -> R1
  - otherwise stay in IDLE
- L1 -> L2 -> L3 -> IDLE, unconditionally.
- R1 -> R2 -> R3 -> IDLE, unconditionally.
- HAZ -> IDLE.
- Once a sequence starts it always completes. Inputs are re-examined only in IDLE.
- Held requests therefore repeat with period 4 ticks (turn) or 2 ticks (hazard).

Lamp decode:
- Turn bank patterns:
  - L1/R1 -> 001
  - L2/R2 -> 011
  - L3/R3 -> 111
- HAZ -> both banks 111.
- IDLE -> both banks 000.
- Non-turning bank during L*/R* -> 000.

Brake overlay:
- When brake=1, every bank not currently sequencing a turn shows 111.
- In IDLE and HAZ this means both banks show 111.
- A sequencing bank is unaffected by brake.
- Consequence: hazard+brake gives steady 111/111.

Output timing:
- lamp_l/lamp_r are registered: lamp <= decode(state_next, brake) on every clk.
- Lamps therefore match the new state in the same cycle the state changes.
- Brake changes appear 1 clk after sampling, independent of tick.

Boundaries:
- Turn request dropped mid-sequence: sequence still finishes; no new sequence starts.
- left and right together: treated as hazard.
- Request rising while not in IDLE: ignored until IDLE is evaluated on a tick.
- Request present for less than one tick window and absent at the tick edge: never seen.

Decomposition:
- Shared package tbird_pkg holds:
  - state enum (IDLE, L1, L2, L3, R1, R2, R3, HAZ)
  - lamp pattern constants: LAMP_OFF=000, LAMP_1=001, LAMP_2=011, LAMP_3=111
- One sub-module, tbird_tick: parameterised prescaler with ports clk, reset, tick.
- FSM and decode live in tbird_controller.

Test Plan:
- TICK_DIV=1, reset 1 clk, then left=1 held.
  - Required: lamp_l per clk = 001, 011, 111, 000, 001, …
  - lamp_r = 000 throughout.
- TICK_DIV=1, right=1 for exactly 1 clk, then 0.
  - Required: lamp_r = 001, 011, 111, 000.
  - Then lamp_r stays 000 with no restart.
- TICK_DIV=1, hazard=1 held (repeat with left=right=1, hazard=0).
  - Required: both banks alternate 111, 000, 111, 000.
- TICK_DIV=1, brake=1 and left=1 held.
  - Required: lamp_r = 111 steady; lamp_l = 001, 011, 111, then 111 (IDLE + brake), then 001, …
  - Dropping brake makes lamp_r 000 on the next clk.
- TICK_DIV=1, left=1, reset asserted while lamp_l = 011.
  - Required: next clk lamp_l = 000 and lamp_r = 000.
  - First clk after reset deasserts, with left still 1: lamp_l = 001.
- TICK_DIV=4, right=1 held.
  - Required: lamp_r holds 001 for 4 clks, then 011 for 4 clks, then 111 for 4, then 000 for 4.
  - Brake toggles mid-window reflect on lamp_l within 1 clk.

Source files
------------

// File: rtl/tbird_pkg.sv
// Shared types and lamp patterns for the Thunderbird tail-light controller.
package tbird_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        L1   = 3'd1,
        L2   = 3'd2,
        L3   = 3'd3,
        R1   = 3'd4,
        R2   = 3'd5,
        R3   = 3'd6,
        HAZ  = 3'd7
    } state_t;

    // Bank patterns; bit0 is the innermost lamp, bit2 the outermost.
    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_1   = 3'b001;
    localparam logic [2:0] LAMP_2   = 3'b011;
    localparam logic [2:0] LAMP_3   = 3'b111;

endpackage

// File: rtl/tbird_tick.sv
// Prescaler: counts 0..TICK_DIV-1 and flags the last count as the sequencer tick.
module tbird_tick #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick = (count_q == LAST);

    // Wrap to zero on the tick, otherwise increment.
    always_comb begin
        count_d = tick ? '0 : count_q + 1'b1;
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tbird_controller.sv
// Thunderbird tail-light controller: turn sequencing, hazard flash and brake overlay.
module tbird_controller
    import tbird_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left,
    input  logic       right,
    input  logic       hazard,
    input  logic       brake,
    output logic [2:0] lamp_l,
    output logic [2:0] lamp_r
);

    logic       tick;
    state_t     state_q;
    state_t     state_d;
    logic [2:0] lamp_l_q;
    logic [2:0] lamp_l_d;
    logic [2:0] lamp_r_q;
    logic [2:0] lamp_r_d;

    tbird_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Next state: requests are only decoded from IDLE; sequences always run to completion.
    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (hazard || (left && right)) state_d = HAZ;
                    else if (left)                 state_d = L1;
                    else if (right)                state_d = R1;
                    else                           state_d = IDLE;
                end
                L1:      state_d = L2;
                L2:      state_d = L3;
                R1:      state_d = R2;
                R2:      state_d = R3;
                default: state_d = IDLE; // L3, R3, HAZ
            endcase
        end
    end

    // Lamp decode of the upcoming state; brake lights any bank not sequencing a turn.
    always_comb begin
        lamp_l_d = brake ? LAMP_3 : LAMP_OFF;
        lamp_r_d = brake ? LAMP_3 : LAMP_OFF;
        case (state_d)
            L1:  lamp_l_d = LAMP_1;
            L2:  lamp_l_d = LAMP_2;
            L3:  lamp_l_d = LAMP_3;
            R1:  lamp_r_d = LAMP_1;
            R2:  lamp_r_d = LAMP_2;
            R3:  lamp_r_d = LAMP_3;
            HAZ: begin
                lamp_l_d = LAMP_3;
                lamp_r_d = LAMP_3;
            end
            default: ; // IDLE keeps the brake-only pattern
        endcase
    end

    // State and registered lamp outputs; lamps update every clk so brake is tick-independent.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            lamp_l_q <= LAMP_OFF;
            lamp_r_q <= LAMP_OFF;
        end else begin
            state_q  <= state_d;
            lamp_l_q <= lamp_l_d;
            lamp_r_q <= lamp_r_d;
        end
    end

    assign lamp_l = lamp_l_q;
    assign lamp_r = lamp_r_q;

endmodule

// File: tb/tb_tbird_controller.sv
// Directed bench for tbird_controller at TICK_DIV=1 and TICK_DIV=4.
module tb_tbird_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       left;
    logic       right;
    logic       hazard;
    logic       brake;
    logic [2:0] lamp_l1, lamp_r1;
    logic [2:0] lamp_l4, lamp_r4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tbird_controller #(.TICK_DIV(1)) dut1 (
        .clk    (clk),
        .reset  (reset),
        .left   (left),
        .right  (right),
        .hazard (hazard),
        .brake  (brake),
        .lamp_l (lamp_l1),
        .lamp_r (lamp_r1)
    );

    tbird_controller #(.TICK_DIV(4)) dut4 (
        .clk    (clk),
        .reset  (reset),
        .left   (left),
        .right  (right),
        .hazard (hazard),
        .brake  (brake),
        .lamp_l (lamp_l4),
        .lamp_r (lamp_r4)
    );

    task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end else begin
            $display("ok   %s: %b", tag, got);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        left = 0; right = 0; hazard = 0; brake = 0;
        step();
        reset = 1'b0;
    endtask

    logic [2:0] exp_seq[8];
    logic [2:0] exp_r;
    logic [2:0] exp_l;

    initial begin
        reset = 1; left = 0; right = 0; hazard = 0; brake = 0;
        #1;

        // 1: reset state, then left held
        do_reset();
        chk("rst_l1", lamp_l1, 3'b000);
        chk("rst_r1", lamp_r1, 3'b000);
        chk("rst_l4", lamp_l4, 3'b000);
        chk("rst_r4", lamp_r4, 3'b000);
        exp_seq = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b001, 3'b011, 3'b111, 3'b000};
        left = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("left_l[%0d]", i), lamp_l1, exp_seq[i]);
            chk($sformatf("left_r[%0d]", i), lamp_r1, 3'b000);
        end

        // 2: right pulsed for one clk, no restart
        do_reset();
        exp_seq = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        right = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            right = 0;
            chk($sformatf("rpulse_r[%0d]", i), lamp_r1, exp_seq[i]);
            chk($sformatf("rpulse_l[%0d]", i), lamp_l1, 3'b000);
        end

        // 3a: hazard held
        do_reset();
        hazard = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_l = (i % 2 == 0) ? 3'b111 : 3'b000;
            chk($sformatf("haz_l[%0d]", i), lamp_l1, exp_l);
            chk($sformatf("haz_r[%0d]", i), lamp_r1, exp_l);
        end

        // 3b: left+right acts as hazard
        do_reset();
        left = 1; right = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_l = (i % 2 == 0) ? 3'b111 : 3'b000;
            chk($sformatf("lr_l[%0d]", i), lamp_l1, exp_l);
            chk($sformatf("lr_r[%0d]", i), lamp_r1, exp_l);
        end

        // 3c: hazard with brake is steady on
        do_reset();
        hazard = 1; brake = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("hazbrk_l[%0d]", i), lamp_l1, 3'b111);
            chk($sformatf("hazbrk_r[%0d]", i), lamp_r1, 3'b111);
        end

        // 4: brake + left held, then brake dropped during L1
        do_reset();
        brake = 1; left = 1;
        exp_seq = '{3'b001, 3'b011, 3'b111, 3'b111, 3'b001, 3'b000, 3'b000, 3'b000};
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("brk_l[%0d]", i), lamp_l1, exp_seq[i]);
            chk($sformatf("brk_r[%0d]", i), lamp_r1, 3'b111);
        end
        brake = 0;
        step();
        chk("brkdrop_r", lamp_r1, 3'b000);
        chk("brkdrop_l", lamp_l1, 3'b011);

        // 5: reset mid-sequence
        do_reset();
        left = 1;
        step();
        chk("midrst_pre0", lamp_l1, 3'b001);
        step();
        chk("midrst_pre1", lamp_l1, 3'b011);
        reset = 1;
        step();
        chk("midrst_l", lamp_l1, 3'b000);
        chk("midrst_r", lamp_r1, 3'b000);
        reset = 0;
        step();
        chk("postrst_l", lamp_l1, 3'b001);

        // 6: TICK_DIV=4, right held, brake pulses during R2 window
        do_reset();
        right = 1;
        for (int i = 0; i < 20; i++) begin
            brake = (i == 9 || i == 10);
            step();
            if (i < 3)       exp_r = 3'b000;
            else if (i < 7)  exp_r = 3'b001;
            else if (i < 11) exp_r = 3'b011;
            else if (i < 15) exp_r = 3'b111;
            else if (i < 19) exp_r = 3'b000;
            else             exp_r = 3'b001;
            exp_l = brake ? 3'b111 : 3'b000;
            chk($sformatf("div4_r[%0d]", i), lamp_r4, exp_r);
            chk($sformatf("div4_l[%0d]", i), lamp_l4, exp_l);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
